lu_arbiter: RTL and testbench
=============================

# lu_arbiter

Two-requester arbiter and sequencer for the shared 32-bit bitwise logic unit (AND/OR/XOR/NOR) of the CPU datapath. Requester 0 is the EX stage and requester 1 is the multicycle coprocessor path; both issue operations through valid/ready handshakes. The block grants one requester per cycle with round-robin fairness, computes the result through the shared unit, and holds a registered response until the owning requester accepts it. It has a one-entry response register, no request buffering, and a single cycle of compute latency.

## Interface
- WIDTH, 32, operand and result width.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_op  in  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NOR.
- req0_a, req0_b  in  WIDTH  operands.
- req0_ready  out  1  requester 0 accepted this cycle when valid is also high.
- req1_valid, req1_op, req1_a, req1_b, req1_ready  same as requester 0.
- resp0_valid  out  1  response register holds a result owned by requester 0.
- resp1_valid  out  1  response register holds a result owned by requester 1.
- resp0_ready, resp1_ready  in  1  the owning requester consumes the response.
- resp_data  out  WIDTH  registered result.
- resp_zero  out  1  registered flag, high when resp_data is all zero.

## Operation
- State machine with two states:
  - IDLE: the response register is empty.
  - HOLD: the response register is full and owned by `owner` (1 bit).
- `last` register (1 bit) records the most recently granted requester.
- Grant (combinational):
  - Only one requester valid: grant it.
  - Both valid: grant the requester opposite to `last`.
- `slot_free` = (state==IDLE) or (HOLD and the owner's resp ready is high).
- reqN_ready = slot_free and grant==N and reqN_valid.
  - The non-granted requester's ready is always 0.
  - Ready depends on valid.
- Accept = valid & ready. On accept:
  - resp_data <= op(a,b).
  - resp_zero <= (op(a,b)==0).
  - owner <= N, last <= N, state <= HOLD.
  - respN_valid <= 1, the other resp valid <= 0.
- HOLD, owner's ready high, no accept: state <= IDLE and both resp valids <= 0. resp_data and resp_zero keep their last values.
- HOLD, owner's ready high, accept in the same cycle: back-to-back reload; the new result replaces the old without a bubble.
- HOLD, owner's ready low: all registers hold and both req ready are 0.
- The non-owner's resp ready is ignored.
- Requesters hold valid, op, and operands stable until accepted. The block does not check this.
- At most one of resp0_valid and resp1_valid is ever high.
- Results are pure bitwise, WIDTH bits. There is no carry or overflow.

## Timing
- Reset values:
  - state IDLE, last = 1 (requester 0 wins first contention), owner = 0.
  - resp0_valid = resp1_valid = 0, resp_data = 0, resp_zero = 0.
  - req0_ready = req1_ready = 0 while rst is high.
- Latency: accept at edge N, response visible after edge N, consumable in cycle N+1.
- Throughput: one operation per cycle when the owner consumes every cycle.
- Asserting rst mid-HOLD discards the pending response immediately (asynchronous clear). Any in-flight request is not accepted.
- Fairness: under continuous contention, grants alternate 0,1,0,1…. A single valid requester is granted every free slot regardless of `last`.

## Test plan
- Reset, then req0 OR a=0x0000F0F0 b=0x0F0F0000 -> req0_ready=1 that cycle; next cycle resp0_valid=1, resp_data=0x0F0FF0F0, resp_zero=0, resp1_valid=0.
- Both valid continuously, resp ready held high, 4 cycles -> grant order 0,1,0,1. Each response appears one cycle after its accept with the matching owner's valid.
- req1 AND a=0xFFFF0000 b=0x0000FFFF -> resp_data=0, resp_zero=1. Then hold resp1_ready=0 for 3 cycles -> response stable, req0_ready=0 although req0_valid=1. Then assert resp1_ready -> req0 accepted the same cycle.
- Back-to-back req0 XOR 0xAAAAAAAA^0x55555555, then NOR 0^0 with resp0_ready always high -> consecutive cycles show 0xFFFFFFFF then 0xFFFFFFFF; the state never returns to IDLE between them.
- In HOLD owned by 0, assert resp1_ready=1 with resp0_ready=0 -> no change; response is not consumed.
- Assert rst asynchronously mid-HOLD -> resp valids and resp_data go to 0 without waiting for a clock edge. After release, the first contention goes to requester 0.

Source files
------------

// File: rtl/lu_arbiter.sv
// rtl/lu_arbiter.sv - two-requester round-robin arbiter and sequencer for the shared bitwise logic unit
module lu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             resp0_valid,
    output logic             resp1_valid,
    input  logic             resp0_ready,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_zero
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic             owner, owner_nxt;
    logic             last, last_nxt;
    logic [WIDTH-1:0] resp_data_nxt;
    logic             resp_zero_nxt;

    logic             grant;
    logic             owner_rdy;
    logic             slot_free;
    logic             accept;
    logic [1:0]       g_op;
    logic [WIDTH-1:0] g_a;
    logic [WIDTH-1:0] g_b;
    logic [WIDTH-1:0] result;

    // Round-robin grant: a lone requester always wins, contention goes opposite to the last winner.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
        owner_rdy  = owner ? resp1_ready : resp0_ready;
        slot_free  = (state == IDLE) || owner_rdy;
        req0_ready = ~rst && slot_free && (grant == 1'b0) && req0_valid;
        req1_ready = ~rst && slot_free && (grant == 1'b1) && req1_valid;
        accept     = req0_ready || req1_ready;
    end

    // Shared logic unit fed by the granted requester's operation.
    always_comb begin
        g_op = grant ? req1_op : req0_op;
        g_a  = grant ? req1_a  : req0_a;
        g_b  = grant ? req1_b  : req0_b;
        case (g_op)
            2'b00:   result = g_a & g_b;
            2'b01:   result = g_a | g_b;
            2'b10:   result = g_a ^ g_b;
            default: result = ~(g_a | g_b);
        endcase
    end

    // Next-state: load on accept (also back-to-back over a consumed response), drain on consume.
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        last_nxt      = last;
        resp_data_nxt = resp_data;
        resp_zero_nxt = resp_zero;
        if (accept) begin
            state_nxt     = HOLD;
            owner_nxt     = grant;
            last_nxt      = grant;
            resp_data_nxt = result;
            resp_zero_nxt = (result == '0);
        end else if (state == HOLD && owner_rdy) begin
            state_nxt = IDLE;
        end
    end

    // State and response registers; reset clears a pending response immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            resp_data <= '0;
            resp_zero <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            last      <= last_nxt;
            resp_data <= resp_data_nxt;
            resp_zero <= resp_zero_nxt;
        end
    end

    // The owner bit only means something while the register is full, so valids cannot both be high.
    always_comb begin
        resp0_valid = (state == HOLD) && !owner;
        resp1_valid = (state == HOLD) && owner;
    end

endmodule

// File: tb/tb_lu_arbiter.sv
// tb/tb_lu_arbiter.sv - scoreboard bench for lu_arbiter with randomized traffic and directed scenarios
module tb_lu_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic [1:0]       req0_op = '0, req1_op = '0;
    logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic             req0_ready, req1_ready;
    logic             resp0_valid, resp1_valid;
    logic             resp0_ready = 1'b0, resp1_ready = 1'b0;
    logic [WIDTH-1:0] resp_data;
    logic             resp_zero;

    lu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
        .resp_data(resp_data), .resp_zero(resp_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit               owner;
        logic [WIDTH-1:0] data;
        bit               zero;
    } resp_t;

    resp_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    // reference model state
    bit    held = 0;
    bit    howner = 0;
    bit    last_g = 1;
    bit    acc0 = 0, acc1 = 0;
    bit    grant_log[$];

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] lu(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // Monitor: whatever the DUT presents must match the oldest expected response; pop on consumption.
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() > 0) begin
                chk("resp0_valid", resp0_valid, !exp_q[0].owner);
                chk("resp1_valid", resp1_valid, exp_q[0].owner);
                chk("resp_data", resp_data, exp_q[0].data);
                chk("resp_zero", resp_zero, exp_q[0].zero);
                if (exp_q[0].owner ? resp1_ready : resp0_ready) void'(exp_q.pop_front());
            end else begin
                chk("resp_valids_empty", {resp1_valid, resp0_valid}, 0);
            end
        end
    end

    // One clock: model predicts readies from the arbitration rules and pushes expected results.
    task automatic step();
        bit cons, free, g, e0, e1;
        resp_t r;
        @(negedge clk);
        #1;
        cons = held && (howner ? resp1_ready : resp0_ready);
        free = !held || cons;
        if (req0_valid && req1_valid) g = !last_g;
        else g = req1_valid;
        e0 = free && req0_valid && !g;
        e1 = free && req1_valid && g;
        chk("req0_ready", req0_ready, e0);
        chk("req1_ready", req1_ready, e1);
        if (e0 || e1) begin
            r.owner = g;
            r.data  = g ? lu(req1_op, req1_a, req1_b) : lu(req0_op, req0_a, req0_b);
            r.zero  = (r.data == 0);
            exp_q.push_back(r);
            held = 1; howner = g; last_g = g;
            grant_log.push_back(g);
        end else if (cons) begin
            held = 0;
        end
        acc0 = e0; acc1 = e1;
        @(posedge clk);
        #1;
        if (acc0) req0_valid = 1'b0;
        if (acc1) req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_resp_valids", {resp1_valid, resp0_valid}, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_zero", resp_zero, 0);
        exp_q.delete();
        held = 0; howner = 0; last_g = 1;
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic arm0(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    endtask

    task automatic arm1(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    endtask

    task automatic drain();
        req0_valid = 1'b0; req1_valid = 1'b0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        repeat (2) step();
    endtask

    initial begin
        do_reset();

        // single OR from requester 0
        resp0_ready = 1'b1;
        arm0(2'b01, 32'h0000F0F0, 32'h0F0F0000);
        #1;
        chk("t1_req0_ready", req0_ready, 1);
        step();
        chk("t1_resp0_valid", resp0_valid, 1);
        chk("t1_resp1_valid", resp1_valid, 0);
        chk("t1_resp_data", resp_data, 32'h0F0FF0F0);
        chk("t1_resp_zero", resp_zero, 0);
        drain();

        // continuous contention after reset alternates starting with requester 0
        do_reset();
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        grant_log.delete();
        for (int i = 0; i < 4; i++) begin
            arm0(2'(i), $urandom, $urandom);
            arm1(2'(i + 1), $urandom, $urandom);
            step();
        end
        chk("fair_count", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) chk($sformatf("fair_grant%0d", i), grant_log[i], i % 2);
        drain();

        // requester 1 zero result, held while requester 0 waits
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        arm1(2'b00, 32'hFFFF0000, 32'h0000FFFF);
        step();
        chk("t3_resp_zero", resp_zero, 1);
        chk("t3_resp_data", resp_data, 0);
        arm0(2'b10, 32'h12345678, 32'h0F0F0F0F);
        repeat (3) step();
        chk("t3_stall_req0_ready", req0_ready, 0);
        resp1_ready = 1'b1;
        #1;
        chk("t3_release_req0_ready", req0_ready, 1);
        step();
        chk("t3_owner0", resp0_valid, 1);
        drain();

        // back-to-back XOR then NOR, no bubble
        resp0_ready = 1'b1;
        arm0(2'b10, 32'hAAAAAAAA, 32'h55555555);
        step();
        arm0(2'b11, 32'h0, 32'h0);
        step();
        chk("b2b_valid", resp0_valid, 1);
        chk("b2b_data", resp_data, 32'hFFFFFFFF);
        drain();

        // non-owner ready is ignored
        resp0_ready = 1'b0; resp1_ready = 1'b1;
        arm0(2'b01, 32'h00000003, 32'h00000100);
        step();
        step();
        step();
        chk("nonowner_held", resp0_valid, 1);
        chk("nonowner_data", resp_data, 32'h00000103);

        // asynchronous reset mid-HOLD
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valids", {resp1_valid, resp0_valid}, 0);
        chk("arst_data", resp_data, 0);
        exp_q.delete();
        held = 0; howner = 0; last_g = 1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        arm0(2'b00, 32'hF0F0F0F0, 32'hFFFF0000);
        arm1(2'b01, 32'h1, 32'h2);
        #1;
        chk("arst_first_contention", {req1_ready, req0_ready}, 2'b01);
        step();
        drain();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (!req0_valid && ($urandom_range(0, 3) != 0)) arm0(2'($urandom), $urandom, ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom);
            if (!req1_valid && ($urandom_range(0, 3) != 0)) arm1(2'($urandom), $urandom, ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFF : $urandom);
            resp0_ready = ($urandom_range(0, 9) < 7);
            resp1_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        drain();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
